operand_sequencer: RTL and testbench

//  Control-side counterpart of the ALU operand-source mux: it accepts one R.O.E

---
 rtl/operand_sequencer.sv | 99 +++++++++
 tb/tb_operand_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// operand_sequencer: accepts one instruction per handshake and sequences the ALU through decode, execute and write-back
module operand_sequencer #(
    parameter int IW    = 9,
    parameter int CNT_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid_i,
    input  logic [IW-1:0] instr_i,
    output logic          instr_ready_o,
    output logic [1:0]    alu_src_o,
    output logic [3:0]    to_ext_o,
    output logic [2:0]    to_inc_o,
    output logic [2:0]    rd_addr_o,
    output logic [2:0]    alu_op_o,
    output logic          alu_en_o,
    output logic          wb_en_o,
    output logic          done_o,
    output logic          illegal_o
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;
    state_t            state_q, state_d;
    logic [IW-1:0]     instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_d;
    logic              busy_d;
    logic              ready_d, alu_en_d, wb_en_d, done_d, illegal_d;
    logic [1:0]        src_d;
    logic [3:0]        ext_d;
    logic [2:0]        inc_d, rd_d, aluop_d;
    // state, latched instruction, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            cnt_q         <= '0;
            instr_ready_o <= 1'b1;
            alu_src_o     <= 2'b10;
            to_ext_o      <= '0;
            to_inc_o      <= '0;
            rd_addr_o     <= '0;
            alu_op_o      <= '0;
            alu_en_o      <= 1'b0;
            wb_en_o       <= 1'b0;
            done_o        <= 1'b0;
            illegal_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            cnt_q         <= cnt_d;
            instr_ready_o <= ready_d;
            alu_src_o     <= src_d;
            to_ext_o      <= ext_d;
            to_inc_o      <= inc_d;
            rd_addr_o     <= rd_d;
            alu_op_o      <= aluop_d;
            alu_en_o      <= alu_en_d;
            wb_en_o       <= wb_en_d;
            done_o        <= done_d;
            illegal_o     <= illegal_d;
        end
    end
    // next state: accept in IDLE, decode, count down execute cycles, retire
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (instr_valid_i) begin
                state_d = DECODE;
                instr_d = instr_i;
            end
            DECODE: begin
                state_d = (instr_q[8:6] <= 3'd4) ? EXEC : ERR;
                cnt_d   = (instr_q[8:6] == 3'd4) ? CNT_W'(instr_q[2:0]) : '0;
            end
            EXEC: begin
                state_d = (cnt_q == '0) ? WB : EXEC;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs for the coming state, so every output comes straight from a flop
    always_comb begin
        op_d      = instr_d[8:6];
        busy_d    = state_d inside {DECODE, EXEC, WB};
        ready_d   = state_d == IDLE;
        src_d     = (busy_d && op_d == 3'd0) ? 2'b00 : (busy_d && op_d == 3'd1) ? 2'b01 : 2'b10;
        ext_d     = (busy_d && op_d == 3'd1) ? instr_d[3:0] : 4'd0;
        inc_d     = (busy_d && op_d == 3'd0) ? instr_d[2:0] : 3'd0;
        rd_d      = busy_d ? instr_d[5:3] : 3'd0;
        aluop_d   = (state_d != IDLE) ? op_d : 3'd0;
        alu_en_d  = state_d == EXEC;
        wb_en_d   = state_d == WB;
        done_d    = state_d == WB;
        illegal_d = state_d == ERR;
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: random instruction stream checked cycle by cycle against a trace model
module tb_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid_i = 1'b0;
    logic [8:0] instr_i = '0;
    logic       instr_ready_o, alu_en_o, wb_en_o, done_o, illegal_o;
    logic [1:0] alu_src_o;
    logic [3:0] to_ext_o;
    logic [2:0] to_inc_o, rd_addr_o, alu_op_o;
    int vectors = 0;
    int miscompares = 0;
    localparam logic [19:0] IDLE_V = {1'b1, 2'b10, 17'b0};

    operand_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
        .instr_ready_o(instr_ready_o), .alu_src_o(alu_src_o), .to_ext_o(to_ext_o),
        .to_inc_o(to_inc_o), .rd_addr_o(rd_addr_o), .alu_op_o(alu_op_o),
        .alu_en_o(alu_en_o), .wb_en_o(wb_en_o), .done_o(done_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] obs();
        return {instr_ready_o, alu_src_o, to_ext_o, to_inc_o, rd_addr_o, alu_op_o,
                alu_en_o, wb_en_o, done_o, illegal_o};
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic int last_cycle(input logic [8:0] ins);
        if (ins[8:6] > 3'd4) return 2;
        return (ins[8:6] == 3'd4) ? int'(ins[2:0]) + 3 : 3;
    endfunction

    // expected outputs k cycles after the accept edge: {ready, src, ext, inc, rd, op, alu_en, wb_en, done, illegal}
    function automatic logic [19:0] exp_vec(input logic [8:0] ins, input int k);
        logic [2:0]  op;
        logic [1:0]  src;
        logic [3:0]  ext;
        logic [2:0]  inc;
        logic [19:0] body;
        int          last;
        op   = ins[8:6];
        src  = (op == 3'd0) ? 2'b00 : (op == 3'd1) ? 2'b01 : 2'b10;
        ext  = (op == 3'd1) ? ins[3:0] : 4'd0;
        inc  = (op == 3'd0) ? ins[2:0] : 3'd0;
        body = {1'b0, src, ext, inc, ins[5:3], op, 4'b0000};
        last = last_cycle(ins);
        if (op > 3'd4) begin
            if (k == 1) return body;
            if (k == 2) return {1'b0, 2'b10, 4'd0, 3'd0, 3'd0, op, 4'b0001};
            return IDLE_V;
        end
        if (k == 1) return body;
        if (k < last) return body | 20'b1000;
        if (k == last) return body | 20'b0110;
        return IDLE_V;
    endfunction

    // present ins, then check every cycle through the first idle cycle; optionally hold the next instruction or abort via reset
    task automatic run(input logic [8:0] ins, input logic [8:0] nxt, input bit hold, input int abort_k);
        int last;
        last = last_cycle(ins);
        instr_valid_i = 1'b1;
        instr_i = ins;
        @(posedge clk);
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            chk($sformatf("i%03h_k%0d", ins, k), obs(), exp_vec(ins, k));
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1 chk($sformatf("async_rst_i%03h", ins), obs(), IDLE_V);
                @(negedge clk);
                chk("rst_hold", obs(), IDLE_V);
                rst_n = 1'b1;
                return;
            end
            if (k <= last) begin
                instr_valid_i = hold ? 1'b1 : 1'($urandom);
                instr_i = hold ? nxt : 9'($urandom);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        chk("reset_c0", obs(), IDLE_V);
        @(negedge clk);
        chk("reset_c1", obs(), IDLE_V);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_valid", obs(), IDLE_V);
        run(9'b001_010_011, 9'd0, 1'b0, 0);
        run(9'b000_001_111, 9'd0, 1'b0, 0);
        run(9'b100_011_111, 9'd0, 1'b0, 0);
        run(9'b111_000_000, 9'd0, 1'b0, 0);
        run(9'b100_101_111, 9'b000_110_101, 1'b1, 0);
        run(9'b000_110_101, 9'b011_111_000, 1'b1, 0);
        run(9'b011_111_000, 9'd0, 1'b0, 0);
        run(9'b100_011_111, 9'b001_100_110, 1'b1, 4);
        run(9'b001_100_110, 9'd0, 1'b0, 0);
        run(9'b100_000_000, 9'd0, 1'b0, 0);
        for (int i = 0; i < 60; i++) run(9'($urandom), 9'd0, 1'b0, 0);
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("final_idle", obs(), IDLE_V);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
